// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-requester arbiter.
// Holds the FSM state encoding, sizing constants and a vector rotation helper.
package arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    // Rotate so that result[k] = v[(k + sh) mod 4].
    function automatic logic [NUM_REQ-1:0] rotate_down(input logic [NUM_REQ-1:0] v,
                                                       input logic [1:0] sh);
        logic [NUM_REQ-1:0] r;
        logic [1:0]         idx;
        r = 4'b0000;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx  = 2'(k) + sh;
            r[k] = v[idx];
        end
        return r;
    endfunction

endpackage

// File: rtl/req_arbiter4_if.sv
// Request/grant bundle between four requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface req_arbiter4_if;
    import arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               done;
    logic [NUM_REQ-1:0] gnt;
    logic [1:0]         gnt_id;
    logic               gnt_valid;
    logic               timeout;

    modport master (
        output req, done,
        input  gnt, gnt_id, gnt_valid, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_id, gnt_valid, timeout
    );

endinterface

// File: rtl/arb_pick4.sv
// Combinational highest-index-first picker over a 4-bit request vector.
// Returns a one-hot winner, its binary index and an any-request flag.
module arb_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_vec,
    output logic [NUM_REQ-1:0] one_hot,
    output logic [1:0]         win_idx,
    output logic               any_valid
);

    // Priority encode, index 3 strongest.
    always_comb begin
        one_hot   = 4'b0000;
        win_idx   = 2'd0;
        any_valid = |req_vec;
        if (req_vec[3]) begin
            one_hot = 4'b1000;
            win_idx = 2'd3;
        end else if (req_vec[2]) begin
            one_hot = 4'b0100;
            win_idx = 2'd2;
        end else if (req_vec[1]) begin
            one_hot = 4'b0010;
            win_idx = 2'd1;
        end else if (req_vec[0]) begin
            one_hot = 4'b0001;
            win_idx = 2'd0;
        end else begin
            one_hot = 4'b0000;
            win_idx = 2'd0;
        end
    end

endmodule

// File: rtl/req_arbiter4.sv
// Four-way request arbiter with bounded grant tenure and a one-cycle dead time.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; otherwise fixed priority 3>2>1>0.
module req_arbiter4
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    req_arbiter4_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    arb_state_e         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [NUM_REQ-1:0] gnt_r;
    logic [1:0]         gnt_id_r;
    logic               gnt_valid_r;
    logic               timeout_r;
    logic               armed_r;

    logic [NUM_REQ-1:0] pick_vec_s;
    logic [NUM_REQ-1:0] pick_oh_s;
    logic [1:0]         pick_idx_s;
    logic               pick_any_s;
    logic [NUM_REQ-1:0] win_oh_s;
    logic [1:0]         win_idx_s;
    logic               grant_go_s;

    arb_pick4 u_pick (
        .req_vec   (pick_vec_s),
        .one_hot   (pick_oh_s),
        .win_idx   (pick_idx_s),
        .any_valid (pick_any_s)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_r;

    // Rotating by the last winner puts requester (last-1) in the picker's top slot.
    assign pick_vec_s = rotate_down(bus.req, ptr_r);
    assign win_idx_s  = pick_idx_s + ptr_r;
    assign win_oh_s   = rotate_down(pick_oh_s, 2'd0 - ptr_r);

    // Last-grant pointer, loaded whenever a new tenure starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 2'd0;
        end else if (state_r == IDLE && grant_go_s) begin
            ptr_r <= win_idx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    assign pick_vec_s = bus.req;
    assign win_idx_s  = pick_idx_s;
    assign win_oh_s   = pick_oh_s;
`endif

    // armed_r holds off the very first edge after reset release.
    assign grant_go_s = armed_r && pick_any_s;

    // Arbitration FSM with registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_W'(0);
            gnt_r       <= 4'b0000;
            gnt_id_r    <= 2'd0;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
            armed_r     <= 1'b0;
        end else begin
            armed_r <= 1'b1;
            case (state_r)
                IDLE: begin
                    timeout_r <= 1'b0;
                    cnt_r     <= CNT_W'(0);
                    if (grant_go_s) begin
                        state_r     <= GRANT;
                        gnt_r       <= win_oh_s;
                        gnt_id_r    <= win_idx_s;
                        gnt_valid_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    // done or a dropped request takes precedence over the hold limit.
                    if (bus.done || !bus.req[gnt_id_r] || cnt_r == CNT_LAST) begin
                        state_r     <= RELEASE;
                        gnt_r       <= 4'b0000;
                        gnt_id_r    <= 2'd0;
                        gnt_valid_r <= 1'b0;
                        cnt_r       <= CNT_W'(0);
                        timeout_r   <= !bus.done && bus.req[gnt_id_r];
                    end else begin
                        cnt_r     <= cnt_r + CNT_W'(1);
                        timeout_r <= 1'b0;
                    end
                end
                RELEASE: begin
                    state_r   <= IDLE;
                    timeout_r <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= CNT_W'(0);
                    gnt_r       <= 4'b0000;
                    gnt_id_r    <= 2'd0;
                    gnt_valid_r <= 1'b0;
                    timeout_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_id    = gnt_id_r;
    assign bus.gnt_valid = gnt_valid_r;
    assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_req_arbiter4.sv
// Directed bench for req_arbiter4 (HOLD_MAX=4) with a grant scoreboard.
// Expected grant order for the all-request sweep depends on ARB_ROUND_ROBIN_EN.
module tb_req_arbiter4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   exp_q[$];
    int   sweep_exp[5];

    req_arbiter4_if bus_if ();

    req_arbiter4 #(.HOLD_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every new grant is matched against the next queued expectation.
    initial begin : monitor
        logic prev_valid;
        int   e;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            chk("valid_vs_gnt", 32'(bus_if.gnt_valid), 32'(|bus_if.gnt));
            if (bus_if.gnt_valid) begin
                chk("gnt_onehot", 32'(bus_if.gnt), 32'(4'b0001 << bus_if.gnt_id));
            end else begin
                chk("gnt_id_idle", 32'(bus_if.gnt_id), 32'd0);
            end
            if (bus_if.gnt_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got grant id %0d expected none", bus_if.gnt_id);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_gnt_id", 32'(bus_if.gnt_id), 32'(e));
                end
            end
            prev_valid = bus_if.gnt_valid;
        end
    end

    initial begin : stim
`ifdef ARB_ROUND_ROBIN_EN
        sweep_exp = '{3, 2, 1, 0, 3};
`else
        sweep_exp = '{3, 3, 3, 3, 3};
`endif
        bus_if.req  = 4'b0000;
        bus_if.done = 1'b0;
        step();
        step();
        chk("rst_gnt", 32'(bus_if.gnt), 32'h0);
        chk("rst_valid", 32'(bus_if.gnt_valid), 32'h0);
        chk("rst_timeout", 32'(bus_if.timeout), 32'h0);

        // First grant no earlier than the second edge after reset release.
        rst_n = 1'b1;
        bus_if.req = 4'b0110;
        exp_q.push_back(2);
        step();
        chk("first_edge_nogrant", 32'(bus_if.gnt_valid), 32'h0);
        step();
        chk("grant2_gnt", 32'(bus_if.gnt), 32'h4);
        chk("grant2_id", 32'(bus_if.gnt_id), 32'd2);

        // done -> dead cycle, idle, then regrant to 1.
        bus_if.done = 1'b1;
        step();
        chk("done_rel_gnt", 32'(bus_if.gnt), 32'h0);
        chk("done_rel_timeout", 32'(bus_if.timeout), 32'h0);
        bus_if.done = 1'b0;
        bus_if.req  = 4'b0010;
        exp_q.push_back(1);
        step();
        chk("idle_gnt", 32'(bus_if.gnt), 32'h0);
        step();
        chk("regrant1_gnt", 32'(bus_if.gnt), 32'h2);

        // Requester dropping its request ends the tenure without timeout.
        bus_if.req = 4'b0000;
        step();
        chk("drop_gnt", 32'(bus_if.gnt), 32'h0);
        chk("drop_timeout", 32'(bus_if.timeout), 32'h0);
        step();
        step();

        // Hold limit: 4 granted cycles, timeout pulse, dead cycle, regrant.
        bus_if.req = 4'b1000;
        exp_q.push_back(3);
        step();
        chk("hold_gnt0", 32'(bus_if.gnt), 32'h8);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("hold_gnt", 32'(bus_if.gnt), 32'h8);
            chk("hold_no_timeout", 32'(bus_if.timeout), 32'h0);
        end
        step();
        chk("to_gnt", 32'(bus_if.gnt), 32'h0);
        chk("to_pulse", 32'(bus_if.timeout), 32'h1);
        step();
        chk("to_pulse_end", 32'(bus_if.timeout), 32'h0);
        chk("to_idle_gnt", 32'(bus_if.gnt), 32'h0);
        exp_q.push_back(3);
        step();
        chk("to_regrant", 32'(bus_if.gnt), 32'h8);

        // done coinciding with the last allowed cycle suppresses timeout.
        for (int i = 1; i < 4; i++) begin
            step();
            chk("dl_hold", 32'(bus_if.gnt), 32'h8);
        end
        bus_if.done = 1'b1;
        step();
        chk("dl_gnt", 32'(bus_if.gnt), 32'h0);
        chk("dl_timeout", 32'(bus_if.timeout), 32'h0);
        bus_if.done = 1'b0;
        bus_if.req  = 4'b0000;
        step();
        step();

        // Asynchronous reset in the middle of a tenure.
        bus_if.req = 4'b0001;
        exp_q.push_back(0);
        step();
        chk("pre_rst_gnt", 32'(bus_if.gnt), 32'h1);
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", 32'(bus_if.gnt), 32'h0);
        chk("async_rst_valid", 32'(bus_if.gnt_valid), 32'h0);
        chk("async_rst_timeout", 32'(bus_if.timeout), 32'h0);
        step();
        chk("rst_hold_gnt", 32'(bus_if.gnt), 32'h0);
        rst_n = 1'b1;
        exp_q.push_back(0);
        step();
        chk("post_rst_edge1", 32'(bus_if.gnt_valid), 32'h0);
        step();
        chk("post_rst_grant", 32'(bus_if.gnt), 32'h1);
        bus_if.req = 4'b0000;
        step();
        step();

        // All four requesting, done every tenure.
        bus_if.req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_q.push_back(sweep_exp[t]);
            step();
            chk("sweep_id", 32'(bus_if.gnt_id), 32'(sweep_exp[t]));
            bus_if.done = 1'b1;
            step();
            bus_if.done = 1'b0;
            chk("sweep_rel", 32'(bus_if.gnt_valid), 32'h0);
            step();
        end
        bus_if.req = 4'b0000;
        step();
        step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
